aud_recorder: RTL



---
 rtl/aud_pkg.sv | 15 +
 rtl/i2s_deserializer.sv | 50 +++++
 rtl/aud_recorder.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/aud_pkg.sv
// Shared types and widths for the WM8731 audio capture/playback path.
package aud_pkg;

    localparam int AUD_DATA_W  = 16;
    localparam int SRAM_ADDR_W = 20;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SHIFT,
        S_WRITE,
        S_PAUSE
    } rec_state_t;

endpackage

// File: rtl/i2s_deserializer.sv
// I2S receive front end: LRC falling-edge detect plus an MSB-first shift of one channel word.
// Free-running on every LRC falling edge, so a stereo path can reuse it per channel.
module i2s_deserializer
    import aud_pkg::*;
#(
    parameter int DATA_W = AUD_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lrc,
    input  logic              data,
    output logic              fall,
    output logic              done,
    output logic [DATA_W-1:0] word
);

    localparam int CNT_W = $clog2(DATA_W);

    logic              lrc_q;
    logic              active;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-2:0] shreg;

    // done and word are combinational so the owner can register the sample on the LSB edge itself
    assign fall = lrc_q & ~lrc;
    assign done = active && (bit_cnt == CNT_W'(DATA_W - 1));
    assign word = {shreg, data};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lrc_q   <= 1'b1;
            active  <= 1'b0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            lrc_q <= lrc;
            if (fall) begin
                active  <= 1'b1;
                bit_cnt <= '0;
            end else if (active) begin
                shreg   <= {shreg[DATA_W-3:0], data};
                bit_cnt <= bit_cnt + CNT_W'(1);
                if (done) begin
                    active <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/aud_recorder.sv
// I2S line-in recorder: captures left-channel samples and issues one SRAM write per sample.
// Optional elapsed-seconds timer is enabled with `define AUD_RECORDER_TIMER_EN.
module aud_recorder
    import aud_pkg::*;
#(
    parameter int                ADDR_W      = SRAM_ADDR_W,
    parameter int                DATA_W      = AUD_DATA_W,
    parameter logic [ADDR_W-1:0] MAX_ADDR    = {ADDR_W{1'b1}},
    parameter int                SAMPLE_RATE = 32000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_lrc,
    input  logic              i_data,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    output logic [ADDR_W-1:0] o_address,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_busy,
    output logic              o_full,
    output logic [5:0]        o_record_time
);

    rec_state_t        state;
    logic              pause_pend;
    logic              lrc_fall;
    logic              word_done;
    logic [DATA_W-1:0] word;
    logic              start_idle;

    i2s_deserializer #(
        .DATA_W (DATA_W)
    ) u_deser (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .lrc   (i_lrc),
        .data  (i_data),
        .fall  (lrc_fall),
        .done  (word_done),
        .word  (word)
    );

    // stop outranks start even in idle so a colliding pair never begins a recording
    assign start_idle = (state == S_IDLE) && i_start && !i_stop;
    assign o_busy     = (state != S_IDLE);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            pause_pend <= 1'b0;
            o_address  <= '0;
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_full     <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_idle) begin
                        o_address  <= '0;
                        o_full     <= 1'b0;
                        pause_pend <= 1'b0;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_stop) begin
                        state <= S_IDLE;
                    end else if (i_pause) begin
                        pause_pend <= 1'b0;
                        state      <= S_PAUSE;
                    end else if (lrc_fall) begin
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (i_stop) begin
                        pause_pend <= 1'b0;
                        state      <= S_IDLE;
                    end else begin
                        if (i_pause) begin
                            pause_pend <= 1'b1;
                        end
                        if (word_done) begin
                            o_data  <= word;
                            o_valid <= 1'b1;
                            state   <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    // the strobe is already out, so the address advances even on a stop
                    pause_pend <= 1'b0;
                    if (o_address == MAX_ADDR) begin
                        o_full <= 1'b1;
                        state  <= S_IDLE;
                    end else begin
                        o_address <= o_address + ADDR_W'(1);
                        if (i_stop) begin
                            state <= S_IDLE;
                        end else if (pause_pend || i_pause) begin
                            state <= S_PAUSE;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_PAUSE: begin
                    if (i_stop) begin
                        state <= S_IDLE;
                    end else if (i_start) begin
                        state <= S_WAIT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef AUD_RECORDER_TIMER_EN
    localparam int TCNT_W = $clog2(SAMPLE_RATE + 1);

    logic [TCNT_W-1:0] sample_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sample_cnt    <= '0;
            o_record_time <= '0;
        end else if (start_idle) begin
            sample_cnt    <= '0;
            o_record_time <= '0;
        end else if (state == S_WRITE) begin
            if (sample_cnt == TCNT_W'(SAMPLE_RATE - 1)) begin
                sample_cnt <= '0;
                if (o_record_time != 6'd63) begin
                    o_record_time <= o_record_time + 6'd1;
                end
            end else begin
                sample_cnt <= sample_cnt + TCNT_W'(1);
            end
        end
    end
`else
    assign o_record_time = 6'd0;
`endif

endmodule
